// File: rtl/max_pool_stream.sv
// Streaming POOLxPOOL / stride-POOL signed max-pool with optional ReLU clamp.
// Consumes a raster-ordered pixel stream and keeps one partial max per output column.
module max_pool_stream #(
  parameter int DATA_W = 32,
  parameter int POOL   = 2,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int OUT_W = IMG_W / POOL;
  localparam int OUT_H = IMG_H / POOL;
  localparam int WX_W  = $clog2(POOL);
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  generate
    if ((POOL < 2) || (IMG_W % POOL != 0) || (IMG_H % POOL != 0)) begin : g_bad_dims
      $error("max_pool_stream: POOL must be >= 2 and divide IMG_W and IMG_H");
    end
  endgenerate

  // Valid/ready: a beat moves on a side when its valid and ready are both high at
  // the rising edge; the output registers hold while out_valid && !out_ready.
  logic [WX_W-1:0] wx_q, wx_d;
  logic [OX_W-1:0] ox_q, ox_d;
  logic [WX_W-1:0] wy_q, wy_d;
  logic [OY_W-1:0] oy_q, oy_d;

  logic signed [DATA_W-1:0] run_q, run_d;
  logic signed [DATA_W-1:0] pbuf_q [OUT_W];

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic                     accept;
  logic                     wx_end, ox_end, wy_end, oy_end;
  logic                     win_first, win_done;
  logic signed [DATA_W-1:0] pix, prev, cur, res;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  assign wx_end    = (wx_q == WX_W'(POOL - 1));
  assign ox_end    = (ox_q == OX_W'(OUT_W - 1));
  assign wy_end    = (wy_q == WX_W'(POOL - 1));
  assign oy_end    = (oy_q == OY_W'(OUT_H - 1));
  assign win_first = (wx_q == '0) && (wy_q == '0);
  assign win_done  = accept && wx_end && wy_end;

  // The first pixel of a row segment reads the column buffer; later ones the running register.
  always_comb begin
    pix  = $signed(in_data);
    prev = (wx_q == '0) ? pbuf_q[ox_q] : run_q;
    cur  = (win_first || (pix > prev)) ? pix : prev;
    res  = (relu_en && cur[DATA_W-1]) ? '0 : cur;
  end

  always_comb begin
    wx_d = wx_q;
    ox_d = ox_q;
    wy_d = wy_q;
    oy_d = oy_q;
    if (accept) begin
      if (!wx_end) begin
        wx_d = wx_q + 1'b1;
      end else begin
        wx_d = '0;
        if (!ox_end) begin
          ox_d = ox_q + 1'b1;
        end else begin
          ox_d = '0;
          if (!wy_end) begin
            wy_d = wy_q + 1'b1;
          end else begin
            wy_d = '0;
            oy_d = oy_end ? '0 : oy_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    run_d       = run_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept && !wx_end) begin
      run_d = cur;
    end
    if (win_done) begin
      out_data_d  = res;
      out_valid_d = 1'b1;
      out_last_d  = ox_end && oy_end;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx_q        <= '0;
      ox_q        <= '0;
      wy_q        <= '0;
      oy_q        <= '0;
      run_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      wx_q        <= '0;
      ox_q        <= '0;
      wy_q        <= '0;
      oy_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wx_q        <= wx_d;
      ox_q        <= ox_d;
      wy_q        <= wy_d;
      oy_q        <= oy_d;
      run_q       <= run_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Column partials need no reset: the first row of every window overwrites them.
  always_ff @(posedge clk) begin
    if (accept && !clear && wx_end) begin
      pbuf_q[ox_q] <= cur;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: two instances (2x2 over 4x2, 3x3 over 6x3) checked
// every cycle against a window-max model, plus directed literal expectations.
module tb_max_pool_stream;

  logic        clk;
  logic        rst_n;
  logic        clear     [2];
  logic        relu_en   [2];
  logic [31:0] in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_last  [2];
  logic        bp_en     [2];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0]        exp_q [2][$];
  logic [32:0]        got_q [2][$];
  logic signed [31:0] img   [2][8][8];
  int                 kpix  [2];
  int                 px_q  [$];

  max_pool_stream #(.DATA_W(32), .POOL(2), .IMG_W(4), .IMG_H(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .relu_en(relu_en[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  max_pool_stream #(.DATA_W(32), .POOL(3), .IMG_W(6), .IMG_H(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .relu_en(relu_en[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pool_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction
  function automatic int w_of(input int d);
    return (d == 0) ? 4 : 6;
  endfunction
  function automatic int h_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // ---------------- model + scoreboard (sampled on falling edge) ----------------
  task automatic monitor(input int d);
    int p, w, h, x, y;
    logic signed [31:0] m;
    if (!rst_n) begin
      kpix[d] = 0;
      exp_q[d].delete();
      chk("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
      chk("rst_in_ready", d, 64'(in_ready[d]), 64'd1);
      return;
    end
    chk("in_ready", d, 64'(in_ready[d]), 64'(!out_valid[d] || out_ready[d]));
    chk("out_valid", d, 64'(out_valid[d]), 64'(exp_q[d].size() != 0));
    if (out_valid[d] && exp_q[d].size() != 0)
      chk("out_beat", d, 64'({out_last[d], out_data[d]}), 64'(exp_q[d][0]));
    if (clear[d]) begin
      kpix[d] = 0;
      exp_q[d].delete();
      return;
    end
    if (out_valid[d] && out_ready[d]) begin
      got_q[d].push_back({out_last[d], out_data[d]});
      if (exp_q[d].size() != 0) void'(exp_q[d].pop_front());
    end
    if (in_valid[d] && in_ready[d]) begin
      p = pool_of(d); w = w_of(d); h = h_of(d);
      x = kpix[d] % w;
      y = kpix[d] / w;
      img[d][y][x] = in_data[d];
      if ((x % p == p - 1) && (y % p == p - 1)) begin
        m = img[d][y][x];
        for (int i = y - p + 1; i <= y; i++)
          for (int j = x - p + 1; j <= x; j++)
            if (img[d][i][j] > m) m = img[d][i][j];
        if (relu_en[d] && m < 0) m = 0;
        exp_q[d].push_back({(kpix[d] == w * h - 1), m});
      end
      kpix[d] = (kpix[d] + 1) % (w * h);
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      if (bp_en[d]) out_ready[d] = ($urandom_range(0, 2) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int d, input logic [31:0] v, input logic relu);
    int t;
    logic acc;
    t = 0;
    in_data[d]  = v;
    relu_en[d]  = relu;
    in_valid[d] = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready[d];
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", d, 64'd0, 64'd1);
        break;
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic send_list(input int d, input logic relu);
    foreach (px_q[i]) send(d, px_q[i], relu);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int d);
    int t;
    bp_en[d] = 1'b0;
    @(posedge clk);
    #2;
    out_ready[d] = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (!out_valid[d] && exp_q[d].size() == 0) break;
      t++;
      if (t > 100) begin
        chk("drain_timeout", d, 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input int d, input int idx, input int val, input logic last);
    if (idx >= got_q[d].size()) chk("got_missing", d, 64'(got_q[d].size()), 64'(idx + 1));
    else chk("got_literal", d, 64'(got_q[d][idx]), 64'({last, val}));
  endtask

  task automatic chk_count(input int d, input int n);
    chk("got_count", d, 64'(got_q[d].size()), 64'(n));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'($urandom_range(0, 7)) - 32'd4;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_frames(input int d, input int nfr);
    bp_en[d] = 1'b1;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < w_of(d) * h_of(d); k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 59) == 0) begin
          clear[d] = 1'b1;
          idle(1);
          clear[d] = 1'b0;
        end
        send(d, pick_val(), 1'($urandom_range(0, 1)));
      end
    end
    drain(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0; relu_en[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0;
      out_ready[d] = 1'b1; bp_en[d] = 1'b0; kpix[d] = 0;
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic 2x2 window maxima and out_last placement.
    got_q[0].delete();
    px_q = '{1, -5, 7, 2, 3, 4, -1, 9};
    send_list(0, 1'b0);
    drain(0);
    chk_count(0, 2);
    chk_got(0, 0, 4, 1'b0);
    chk_got(0, 1, 9, 1'b1);

    // All-negative windows with and without the ReLU clamp.
    got_q[0].delete();
    px_q = '{-3, -8, -1, -2, -7, -4, -6, -5};
    send_list(0, 1'b1);
    send_list(0, 1'b0);
    drain(0);
    chk_count(0, 4);
    chk_got(0, 0, 0, 1'b0);
    chk_got(0, 1, 0, 1'b1);
    chk_got(0, 2, -3, 1'b0);
    chk_got(0, 3, -1, 1'b1);

    // 3x3 pool, two back-to-back frames of 0..17.
    got_q[1].delete();
    px_q.delete();
    for (int i = 0; i < 18; i++) px_q.push_back(i);
    send_list(1, 1'b0);
    send_list(1, 1'b0);
    drain(1);
    chk_count(1, 4);
    chk_got(1, 0, 14, 1'b0);
    chk_got(1, 1, 17, 1'b1);
    chk_got(1, 2, 14, 1'b0);
    chk_got(1, 3, 17, 1'b1);

    // Downstream stall on the first output for 5 cycles.
    got_q[0].delete();
    px_q = '{1, -5, 7, 2, 3, 4, -1, 9};
    out_ready[0] = 1'b0;
    fork
      begin
        send_list(0, 1'b0);
        send_list(0, 1'b0);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid[0] && t < 100);
        if (!out_valid[0]) chk("stall_wait", 0, 64'd0, 64'd1);
        for (int i = 0; i < 5; i++) begin
          chk("stall_in_ready", 0, 64'(in_ready[0]), 64'd0);
          chk("stall_data", 0, 64'(out_data[0]), 64'd4);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    drain(0);
    chk_count(0, 4);
    chk_got(0, 0, 4, 1'b0);
    chk_got(0, 1, 9, 1'b1);
    chk_got(0, 2, 4, 1'b0);
    chk_got(0, 3, 9, 1'b1);

    // Clear mid-frame, colliding with an offered pixel, then a fresh frame.
    got_q[0].delete();
    px_q = '{100, 200, 300};
    send_list(0, 1'b0);
    clear[0] = 1'b1;
    in_data[0] = 32'd1000;
    in_valid[0] = 1'b1;
    idle(1);
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    px_q = '{5, 1, 2, 6, 0, 3, 8, -9};
    send_list(0, 1'b0);
    drain(0);
    chk_count(0, 2);
    chk_got(0, 0, 5, 1'b0);
    chk_got(0, 1, 8, 1'b1);

    // Asynchronous reset mid-frame, then a fresh frame.
    got_q[0].delete();
    px_q = '{100, 200, 300};
    send_list(0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    px_q = '{5, 1, 2, 6, 0, 3, 8, -9};
    send_list(0, 1'b0);
    drain(0);
    chk_count(0, 2);
    chk_got(0, 0, 5, 1'b0);
    chk_got(0, 1, 8, 1'b1);

    // Extreme values: most negative and most positive.
    got_q[0].delete();
    px_q = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    send_list(0, 1'b0);
    send_list(0, 1'b1);
    drain(0);
    chk_count(0, 4);
    chk_got(0, 0, 32'h7FFF_FFFF, 1'b0);
    chk_got(0, 1, 32'h8000_0000, 1'b1);
    chk_got(0, 2, 32'h7FFF_FFFF, 1'b0);
    chk_got(0, 3, 0, 1'b1);

    // Randomized traffic with gaps, backpressure, mixed ReLU and rare clears.
    rand_frames(0, 25);
    rand_frames(1, 10);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming, parametrised POOLxPOOL, stride-POOL signed max-pool with optional ReLU clamp.
- Consumes a raster-ordered feature-map stream (one pixel per beat) and emits one pooled value per completed window.
- Keeps a per-output-column partial-max buffer, so no full frame is stored.
- Sits between a convolution/activation stage and the next layer's input stream, and replaces fixed 4-input, enable-gated pooling.

Parameters:
- DATA_W, 32, pixel width in bits, two's-complement signed.
- POOL, 2, window side and stride (>=2).
- IMG_W, 28, input feature-map width in pixels; must be a multiple of POOL.
- IMG_H, 28, input feature-map height in pixels; must be a multiple of POOL.
- Derived: OUT_W = IMG_W/POOL. A non-multiple IMG_W or IMG_H is an elaboration-time error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort; highest priority after reset.
- relu_en  input  1  1: clamp result at 0; 0: plain signed max. Sampled with each accepted pixel.
- in_data  input  DATA_W  input pixel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  DATA_W  pooled result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  qualifies out_valid; set on the final pooled value of a frame.

Behaviour:
- Reset (rst_n low, async):
  - out_data=0, out_valid=0, out_last=0.
  - All position counters = 0.
  - Partial buffer contents: don't care.
  - in_ready is combinational, so it is 1 during and after reset.
- clear=1 at a rising edge: same effect as reset on counters, out_valid and out_last; out_data holds. clear wins over a simultaneous accept.
- Handshakes:
  - in_ready = !out_valid || out_ready.
  - Input beat accepted when in_valid && in_ready.
  - Output beat transferred when out_valid && out_ready.
  - out_data, out_valid and out_last hold stable while out_valid && !out_ready.
- Counters, advancing only on an accepted beat:
  - wx: 0..POOL-1, column inside window.
  - ox: 0..OUT_W-1, output column.
  - wy: 0..POOL-1, row inside window.
  - oy: 0..IMG_H/POOL-1, output row.
  - Order: wx increments; on wrap, ox increments; on ox wrap, wy increments; on wy wrap, oy increments; on oy wrap, all return to 0 (next frame, no gap cycles).
- Partial buffer: OUT_W entries x DATA_W, indexed by ox.
- Per accepted pixel p, with m = buf[ox] (or the running register within a row):
  - wx==0 && wy==0: initialise with p; no compare against stale data.
  - Otherwise: new = signed_max(m, p).
  - The within-row running max is held in a register; it is written to buf[ox] when wx==POOL-1.
- Window completion, on the accepted pixel with wx==POOL-1 && wy==POOL-1:
  - result = signed_max(partial, p).
  - If relu_en: result = (result < 0) ? 0 : result.
  - Next edge: out_data=result, out_valid=1, out_last = (ox==OUT_W-1 && oy==last).
- Latency: 1 cycle from the completing input beat to out_valid.
- Sustained throughput: 1 pixel/cycle while out_ready=1.
- Simultaneous output transfer and new window completion in the same cycle: out_valid stays 1 and out_data takes the new result.
- Transfer with no new completion: out_valid -> 0 and out_last -> 0.
- Equal values: either operand may be chosen; the result is bit-identical.
- Arithmetic: signed compare only, no width growth. Most negative value (e.g. 0x80000000) is handled correctly: with relu_en=1 it becomes 0; with relu_en=0 it passes through.
- Backpressure: while stalled (out_valid && !out_ready), in_ready=0, so no window can complete and no data is lost.
- Reset or clear mid-frame: partial windows are discarded. The next accepted pixel is treated as pixel (0,0) of a new frame.

Test Plan:
- POOL=2, IMG_W=4, IMG_H=2, relu_en=0, input rows [1,-5,7,2] / [3,4,-1,9], out_ready=1 -> two outputs, 4 then 9; out_last=1 only on 9; each 1 cycle after its completing pixel.
- Same dims, relu_en=1, all inputs negative (-3,-8,-1,-2 / -7,-4,-6,-5) -> outputs 0,0. Repeat with relu_en=0 -> -3,-1.
- POOL=3, IMG_W=6, IMG_H=3, values 0..17 in raster order -> outputs 14 then 17; then a second back-to-back frame gives identical results (no stale carry-over).
- Hold out_ready=0 when the first output appears, for 5 cycles -> in_ready=0 and out_data stable for 5 cycles; after release, the full sequence arrives in order with no loss or duplication.
- Assert clear (and separately rst_n=0) after 3 pixels of a frame, then send a full frame -> only the new frame's maxima appear; out_valid=0 immediately after reset.
- Include 0x80000000 and 0x7FFFFFFF in a window -> output 0x7FFFFFFF. Window of all 0x80000000 -> 0x80000000 with relu_en=0, 0 with relu_en=1.
